pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB), sitting beside the decode-stage control unit. Arbitrates three stall sources and drives all pipeline-register write enables, the ID/EX bubble (NoOp) and the IF/ID flush:
- variable-latency data-memory handshake in MEM
- load-use hazard detection in ID
- taken-branch flush from ID

Also maintains a memory-wait timeout and saturating performance counters.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive MEM_WAIT cycles before entering ERROR (1..2^CNT_W-1)
CNT_W, 8, width of the wait-cycle counter
PERF_W, 16, width of each saturating performance counter

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-low (0 = reset)
start_i  in  1  leave IDLE and begin execution
IFID_Op_i  in  7  opcode of instruction in ID
IFID_Rs1_i  in  5  rs1 of instruction in ID
IFID_Rs2_i  in  5  rs2 of instruction in ID
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_Rd_i  in  5  rd of instruction in EX
EXMEM_MemRead_i  in  1  load in MEM
EXMEM_MemWrite_i  in  1  store in MEM
dmem_ack_i  in  1  data memory completes the access this cycle
Branch_taken_i  in  1  branch resolved taken in ID
dmem_req_o  out  1  data memory request
PCWrite_o  out  1  PC update enable
IFID_Write_o  out  1  IF/ID register enable
IFID_Flush_o  out  1  zero IF/ID on next edge
NoOp_o  out  1  insert bubble into ID/EX (zero control signals)
IDEX_Write_o  out  1  ID/EX enable
EXMEM_Write_o  out  1  EX/MEM enable
MEMWB_Write_o  out  1  MEM/WB enable
error_o  out  1  memory timeout, sticky
load_use_cnt_o  out  PERF_W  load-use stall cycles
mem_wait_cnt_o  out  PERF_W  memory stall cycles

Behaviour:
- FSM states: IDLE, RUN, MEM_WAIT, ERROR. Registered state; outputs combinational from state and inputs.
- Reset (rst_i=0, async): state=IDLE, wait counter=0, perf counters=0, error_o=0. Reset mid-MEM_WAIT aborts the access immediately; dmem_req_o drops asynchronously.
- IDLE:
  - All enables 0, NoOp_o=0, IFID_Flush_o=0, dmem_req_o=0.
  - start_i=1 -> RUN on next edge.
- mem_op = EXMEM_MemRead_i | EXMEM_MemWrite_i.
- RUN and MEM_WAIT: dmem_req_o = mem_op.
- mem_stall = dmem_req_o & ~dmem_ack_i.
- Same-cycle ack (single-cycle memory): no stall.
- RUN with mem_stall:
  - PCWrite, IFID_Write, IDEX_Write, EXMEM_Write = 0.
  - MEMWB_Write=1; MEM/WB datapath captures the bubble.
  - Next state MEM_WAIT; wait counter=1.
- MEM_WAIT:
  - Same freeze while dmem_ack_i=0; counter increments each cycle.
  - Counter reaching TIMEOUT_CYCLES -> ERROR.
  - dmem_ack_i=1 -> all enables 1 this cycle, pipeline advances on that edge, -> RUN, counter cleared.
  - Ack on the same cycle the counter hits TIMEOUT: ack wins (-> RUN).
- ERROR: all enables 0, dmem_req_o=0, error_o=1. Left only by reset.
- Load-use, evaluated only in RUN with no mem_stall:
  - Condition: IDEX_MemRead_i & IDEX_Rd_i!=0 & ((IDEX_Rd_i==IFID_Rs1_i & uses_rs1) | (IDEX_Rd_i==IFID_Rs2_i & uses_rs2)).
  - uses_rs1: R, I-ALU, load, store, branch opcodes.
  - uses_rs2: R, store, branch opcodes.
  - Unknown opcode: neither.
  - Response: PCWrite=0, IFID_Write=0, NoOp_o=1; IDEX/EXMEM/MEMWB_Write=1. Exactly one bubble per hazard.
- Branch flush, evaluated only in RUN with no mem_stall and no load-use:
  - Branch_taken_i=1 -> IFID_Flush_o=1, PCWrite=1 (branch target taken by the PC mux), IFID_Write=1.
- Priority: reset > ERROR > mem_stall > load-use > branch flush > normal.
- Normal: all enables 1, NoOp_o=0, IFID_Flush_o=0.
- Perf counters:
  - load_use_cnt_o +1 per load-use stall cycle.
  - mem_wait_cnt_o +1 per cycle mem_stall=1.
  - Both saturate at 2^PERF_W-1, no wrap.

Decomposition:
- Package hazard_pkg holds:
  - Opcode constants: OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011.
  - State enum.
  - uses_rs1/uses_rs2 decode function.
- One sub-module: sat_counter (PERF_W, inc, async active-low reset), instantiated twice.

Test Plan:
- Reset held, then start_i pulse -> IDLE outputs all 0 until the edge after start_i; then all enables 1.
- lw x5 in EX, add x6,x5,x7 in ID -> exactly one cycle PCWrite=0, IFID_Write=0, NoOp_o=1; load_use_cnt_o=1.
  - Repeat with lw x0 -> no stall.
  - Repeat with addi x6,x7 and Rs2 field=5 -> no stall.
- Store in MEM, dmem_ack_i low 3 cycles then high -> 3 frozen cycles, MEM_WAIT for cycles 2-3; release on the ack cycle; mem_wait_cnt_o=3.
- Taken beq in ID, no hazards -> IFID_Flush_o=1 for one cycle, PCWrite=1.
  - Same cycle with a load-use on beq's rs1 -> stall first, flush one cycle later.
- TIMEOUT_CYCLES=4, ack never arrives -> ERROR; error_o=1; enables 0.
  - Later ack ignored; only rst_i=0 clears.
  - Ack on the exact timeout cycle -> RUN, error_o=0.
- rst_i asserted during MEM_WAIT -> dmem_req_o=0 and state IDLE immediately (asynchronous); counters=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: opcode constants, sequencer states and register-use decode for the hazard controller
package hazard_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, ERROR} state_t;
  function automatic logic usesRs1(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
  endfunction
  function automatic logic usesRs2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int PERF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc,
  output logic [PERF_W-1:0] cnt
);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer driving the 5-stage pipeline register enables
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8,
  parameter int PERF_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [6:0]        IFID_Op_i,
  input  logic [4:0]        IFID_Rs1_i,
  input  logic [4:0]        IFID_Rs2_i,
  input  logic              IDEX_MemRead_i,
  input  logic [4:0]        IDEX_Rd_i,
  input  logic              EXMEM_MemRead_i,
  input  logic              EXMEM_MemWrite_i,
  input  logic              dmem_ack_i,
  input  logic              Branch_taken_i,
  output logic              dmem_req_o,
  output logic              PCWrite_o,
  output logic              IFID_Write_o,
  output logic              IFID_Flush_o,
  output logic              NoOp_o,
  output logic              IDEX_Write_o,
  output logic              EXMEM_Write_o,
  output logic              MEMWB_Write_o,
  output logic              error_o,
  output logic [PERF_W-1:0] load_use_cnt_o,
  output logic [PERF_W-1:0] mem_wait_cnt_o
);
  state_t           state;
  logic [CNT_W-1:0] waitCnt;
  logic             active, memStall, loadUse, inRun;
  always_comb begin
    active        = (state == RUN) || (state == MEM_WAIT);
    inRun         = state == RUN;
    dmem_req_o    = active & (EXMEM_MemRead_i | EXMEM_MemWrite_i);
    memStall      = dmem_req_o & ~dmem_ack_i;
    loadUse       = inRun && !memStall && IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                    ((IDEX_Rd_i == IFID_Rs1_i && usesRs1(IFID_Op_i)) ||
                     (IDEX_Rd_i == IFID_Rs2_i && usesRs2(IFID_Op_i)));
    NoOp_o        = loadUse;
    IFID_Flush_o  = inRun && !memStall && !loadUse && Branch_taken_i;
    PCWrite_o     = active && !memStall && !loadUse;
    IFID_Write_o  = PCWrite_o;
    IDEX_Write_o  = active && !memStall;
    EXMEM_Write_o = IDEX_Write_o;
    MEMWB_Write_o = active;
    error_o       = state == ERROR;
  end
  // an ack arriving on the timeout cycle still releases the stall
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else
      case (state)
        IDLE: if (start_i) state <= RUN;
        RUN: if (memStall) begin
          state   <= MEM_WAIT;
          waitCnt <= CNT_W'(1);
        end
        MEM_WAIT: if (!memStall) begin
          state   <= RUN;
          waitCnt <= '0;
        end else if (waitCnt == CNT_W'(TIMEOUT_CYCLES)) state <= ERROR;
        else waitCnt <= waitCnt + 1'b1;
        default: ;
      endcase
  sat_counter #(.PERF_W(PERF_W)) luCounter (
    .clk_i(clk_i), .rst_i(rst_i), .inc(loadUse), .cnt(load_use_cnt_o)
  );
  sat_counter #(.PERF_W(PERF_W)) memCounter (
    .clk_i(clk_i), .rst_i(rst_i), .inc(memStall), .cnt(mem_wait_cnt_o)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scenarios plus random traffic against a stall-streak reference model
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4, PW = 5, SAT = (1 << PW) - 1;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, UNK = 7'b1111111;
  logic clk = 0, rst_i = 0, start_i = 0;
  logic [6:0] IFID_Op_i = I;
  logic [4:0] IFID_Rs1_i = 0, IFID_Rs2_i = 0, IDEX_Rd_i = 0;
  logic IDEX_MemRead_i = 0, EXMEM_MemRead_i = 0, EXMEM_MemWrite_i = 0, dmem_ack_i = 0, Branch_taken_i = 0;
  logic dmem_req_o, PCWrite_o, IFID_Write_o, IFID_Flush_o, NoOp_o;
  logic IDEX_Write_o, EXMEM_Write_o, MEMWB_Write_o, error_o;
  logic [PW-1:0] load_use_cnt_o, mem_wait_cnt_o;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8), .PERF_W(PW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .IFID_Op_i(IFID_Op_i),
    .IFID_Rs1_i(IFID_Rs1_i), .IFID_Rs2_i(IFID_Rs2_i), .IDEX_MemRead_i(IDEX_MemRead_i),
    .IDEX_Rd_i(IDEX_Rd_i), .EXMEM_MemRead_i(EXMEM_MemRead_i), .EXMEM_MemWrite_i(EXMEM_MemWrite_i),
    .dmem_ack_i(dmem_ack_i), .Branch_taken_i(Branch_taken_i), .dmem_req_o(dmem_req_o),
    .PCWrite_o(PCWrite_o), .IFID_Write_o(IFID_Write_o), .IFID_Flush_o(IFID_Flush_o),
    .NoOp_o(NoOp_o), .IDEX_Write_o(IDEX_Write_o), .EXMEM_Write_o(EXMEM_Write_o),
    .MEMWB_Write_o(MEMWB_Write_o), .error_o(error_o), .load_use_cnt_o(load_use_cnt_o),
    .mem_wait_cnt_o(mem_wait_cnt_o)
  );
  int nVec = 0, nBad = 0;
  int mode = 0, streak = 0, luN = 0, memN = 0;
  typedef struct packed {logic req, pc, ifw, fl, noop, idw, exw, mww, err;} outs_t;
  outs_t expo;
  function automatic outs_t model();
    outs_t o;
    logic ms, hz, r1, r2;
    o = '0;
    r1 = IFID_Op_i inside {R, I, LD, ST, BR};
    r2 = IFID_Op_i inside {R, ST, BR};
    if (mode == 2) o.err = 1;
    else if (mode == 1) begin
      o.req  = EXMEM_MemRead_i | EXMEM_MemWrite_i;
      ms     = o.req & ~dmem_ack_i;
      hz     = streak == 0 && !ms && IDEX_MemRead_i && IDEX_Rd_i != 0 &&
               ((IDEX_Rd_i == IFID_Rs1_i && r1) || (IDEX_Rd_i == IFID_Rs2_i && r2));
      o.noop = hz;
      o.fl   = streak == 0 && !ms && !hz && Branch_taken_i;
      o.pc   = !ms && !hz;
      o.ifw  = o.pc;
      o.idw  = !ms;
      o.exw  = !ms;
      o.mww  = 1;
    end
    return o;
  endfunction
  always_comb expo = model();
  always @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      mode <= 0; streak <= 0; luN <= 0; memN <= 0;
    end else if (mode == 0) begin
      if (start_i) mode <= 1;
    end else if (mode == 1) begin
      if (expo.req && !dmem_ack_i) begin
        streak <= streak + 1;
        if (memN < SAT) memN <= memN + 1;
        if (streak + 1 > TO) mode <= 2;
      end else streak <= 0;
      if (expo.noop && luN < SAT) luN <= luN + 1;
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    check("dmem_req", dmem_req_o, expo.req);
    check("PCWrite", PCWrite_o, expo.pc);
    check("IFID_Write", IFID_Write_o, expo.ifw);
    check("IFID_Flush", IFID_Flush_o, expo.fl);
    check("NoOp", NoOp_o, expo.noop);
    check("IDEX_Write", IDEX_Write_o, expo.idw);
    check("EXMEM_Write", EXMEM_Write_o, expo.exw);
    check("MEMWB_Write", MEMWB_Write_o, expo.mww);
    check("error", error_o, expo.err);
    check("load_use_cnt", load_use_cnt_o, luN);
    check("mem_wait_cnt", mem_wait_cnt_o, memN);
  end
  task automatic step();
    @(posedge clk);
    #1;
    start_i = 0; IFID_Op_i = I; IFID_Rs1_i = 0; IFID_Rs2_i = 0; IDEX_Rd_i = 0;
    IDEX_MemRead_i = 0; EXMEM_MemRead_i = 0; EXMEM_MemWrite_i = 0; dmem_ack_i = 0; Branch_taken_i = 0;
  endtask
  task automatic settle();
    #5;
  endtask
  logic [6:0] ops [6] = '{R, I, LD, ST, BR, UNK};
  initial begin
    step(); settle();
    check("rst_pc", PCWrite_o, 0); check("rst_memwb", MEMWB_Write_o, 0); check("rst_cnt", mem_wait_cnt_o, 0);
    step(); rst_i = 1; settle();
    check("idle_pc", PCWrite_o, 0);
    step(); start_i = 1; settle();
    check("start_pc", PCWrite_o, 0); check("start_exw", EXMEM_Write_o, 0);
    step(); settle();
    check("run_pc", PCWrite_o, 1); check("run_mww", MEMWB_Write_o, 1); check("run_req", dmem_req_o, 0);
    step(); IDEX_MemRead_i = 1; IDEX_Rd_i = 5; IFID_Op_i = R; IFID_Rs1_i = 5; IFID_Rs2_i = 7; settle();
    check("lu_noop", NoOp_o, 1); check("lu_pc", PCWrite_o, 0); check("lu_ifw", IFID_Write_o, 0); check("lu_idw", IDEX_Write_o, 1);
    step(); settle();
    check("lu_after_noop", NoOp_o, 0); check("lu_after_pc", PCWrite_o, 1); check("lu_cnt", load_use_cnt_o, 1);
    step(); IDEX_MemRead_i = 1; IFID_Op_i = R; settle();
    check("x0_noop", NoOp_o, 0);
    step(); IDEX_MemRead_i = 1; IDEX_Rd_i = 5; IFID_Op_i = I; IFID_Rs1_i = 7; IFID_Rs2_i = 5; settle();
    check("addi_noop", NoOp_o, 0); check("addi_pc", PCWrite_o, 1);
    for (int k = 0; k < 3; k++) begin
      step(); EXMEM_MemWrite_i = 1; settle();
      check("st_req", dmem_req_o, 1); check("st_pc", PCWrite_o, 0); check("st_exw", EXMEM_Write_o, 0); check("st_mww", MEMWB_Write_o, 1);
    end
    step(); EXMEM_MemWrite_i = 1; dmem_ack_i = 1; settle();
    check("st_rel_pc", PCWrite_o, 1); check("st_rel_exw", EXMEM_Write_o, 1);
    step(); settle();
    check("st_cnt", mem_wait_cnt_o, 3);
    step(); IFID_Op_i = BR; IFID_Rs1_i = 1; IFID_Rs2_i = 2; Branch_taken_i = 1; settle();
    check("br_flush", IFID_Flush_o, 1); check("br_pc", PCWrite_o, 1); check("br_ifw", IFID_Write_o, 1);
    step(); settle();
    check("br_after", IFID_Flush_o, 0);
    step(); IDEX_MemRead_i = 1; IDEX_Rd_i = 3; IFID_Op_i = BR; IFID_Rs1_i = 3; Branch_taken_i = 1; settle();
    check("brlu_flush", IFID_Flush_o, 0); check("brlu_noop", NoOp_o, 1);
    step(); IFID_Op_i = BR; IFID_Rs1_i = 3; Branch_taken_i = 1; settle();
    check("brlu_flush2", IFID_Flush_o, 1); check("brlu_cnt", load_use_cnt_o, 2);
    for (int k = 0; k < 5; k++) begin
      step(); EXMEM_MemRead_i = 1; settle();
      check("to_pc", PCWrite_o, 0);
    end
    step(); EXMEM_MemRead_i = 1; settle();
    check("to_err", error_o, 1); check("to_pc_err", PCWrite_o, 0); check("to_mww", MEMWB_Write_o, 0); check("to_req", dmem_req_o, 0);
    step(); EXMEM_MemRead_i = 1; dmem_ack_i = 1; settle();
    check("to_ack_err", error_o, 1); check("to_ack_pc", PCWrite_o, 0);
    step(); rst_i = 0; settle();
    check("to_rst_err", error_o, 0);
    step(); rst_i = 1; start_i = 1;
    for (int k = 0; k < 4; k++) begin
      step(); EXMEM_MemRead_i = 1; settle();
    end
    step(); EXMEM_MemRead_i = 1; dmem_ack_i = 1; settle();
    check("tack_pc", PCWrite_o, 1); check("tack_err", error_o, 0);
    step(); settle();
    check("tack_run", PCWrite_o, 1); check("tack_err2", error_o, 0); check("tack_cnt", mem_wait_cnt_o, 4);
    for (int k = 0; k < 3; k++) begin
      step(); EXMEM_MemRead_i = 1;
    end
    step(); EXMEM_MemRead_i = 1; #2; rst_i = 0; #1;
    check("arst_req", dmem_req_o, 0); check("arst_pc", PCWrite_o, 0); check("arst_mcnt", mem_wait_cnt_o, 0); check("arst_lcnt", load_use_cnt_o, 0);
    step(); rst_i = 1; start_i = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      rst_i = ($urandom_range(0, 99) != 0) && !(mode == 2 && $urandom_range(0, 7) == 0);
      start_i = $urandom_range(0, 3) == 0;
      IFID_Op_i = ops[$urandom_range(0, 5)];
      IFID_Rs1_i = 5'($urandom_range(0, 3));
      IFID_Rs2_i = 5'($urandom_range(0, 3));
      IDEX_Rd_i = 5'($urandom_range(0, 3));
      IDEX_MemRead_i = 1'($urandom_range(0, 1));
      EXMEM_MemRead_i = $urandom_range(0, 3) == 0;
      EXMEM_MemWrite_i = $urandom_range(0, 3) == 0;
      dmem_ack_i = $urandom_range(0, 2) == 0;
      Branch_taken_i = $urandom_range(0, 3) == 0;
    end
    step(); settle();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
